// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: RAM handshake states,
// arbiter grant states and default arbitration limits.
package cpu_types_pkg;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DGRANT = 2'd1,
      IGRANT = 2'd2
   } arb_state_t;

   localparam int BURST_MAX_DEF  = 4;
   localparam int STARVE_MAX_DEF = 8;
   localparam int CNT_W_DEF      = 4;

endpackage

// File: rtl/mem_arbiter_sat.sv
// Saturating up-counter with priority clear; tracks how long the
// icache has been left waiting without a grant.
module mem_arbiter_sat #(
   parameter int W   = 4,
   parameter int MAX = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   localparam logic [W-1:0] LIM = W'(MAX);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != LIM)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache and dcache word requests onto one RAM port:
// dcache-first with burst hold, icache protected by a starvation bound.
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int BURST_MAX  = BURST_MAX_DEF,
   parameter int STARVE_MAX = STARVE_MAX_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dwait,
   output logic [31:0] dload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  ramstate_t   ramstate
);

   localparam logic [CNT_W-1:0] BURST_LIM  = CNT_W'(BURST_MAX);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   arb_state_t       state_q, state_d;
   logic [CNT_W-1:0] beat_q, beat_d;
   logic [CNT_W-1:0] beat_inc;
   logic [CNT_W-1:0] starve;
   logic             access;
   logic             dreq;
   logic             starved;
   logic             starve_clr;
   logic             starve_inc;

   assign access   = (ramstate == ACCESS);
   assign dreq     = dREN | dWEN;
   assign starved  = (starve == STARVE_LIM);
   assign beat_inc = beat_q + CNT_W'(1);

   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = 1'b1;
      iload    = '0;
      dwait    = 1'b1;
      dload    = '0;
      unique case (state_q)
         IDLE: begin
            if (starved && iREN) begin
               state_d = IGRANT;
            end else if (dreq) begin
               state_d = DGRANT;
            end else if (iREN) begin
               state_d = IGRANT;
            end
         end
         DGRANT: begin
            ramaddr  = daddr;
            ramstore = dstore;
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            dwait    = ~access;
            dload    = access ? ramload : '0;
            if (access) begin
               beat_d = beat_inc;
            end
            // a burst yields once it fills its quota or icache is starved
            if (!dreq ||
                (access && (beat_inc == BURST_LIM)) ||
                (access && starved)) begin
               state_d = IDLE;
               beat_d  = '0;
            end
         end
         IGRANT: begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
            iwait   = ~access;
            iload   = access ? ramload : '0;
            if (access || !iREN) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            beat_d  = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
      end
   end

   assign starve_clr = ~iREN |
                       ((state_d == IGRANT) && (state_q != IGRANT));
   assign starve_inc = iREN & (state_q != IGRANT);

   mem_arbiter_sat #(
      .W   (CNT_W),
      .MAX (STARVE_MAX)
   ) u_starve (
      .clk_i (CLK),
      .rst_i (RST),
      .clr_i (starve_clr),
      .inc_i (starve_inc),
      .cnt_o (starve)
   );

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed checks of mem_arbiter against a
// grant-owner model of the arbitration rules.
module tb_mem_arbiter;
   import cpu_types_pkg::*;

   localparam int BM = 4;
   localparam int SM = 8;

   logic        CLK = 1'b0;
   logic        RST;
   logic        iREN, dREN, dWEN;
   logic [31:0] iaddr, daddr, dstore, ramload;
   ramstate_t   ramstate;
   logic        iwait, dwait, ramREN, ramWEN;
   logic [31:0] iload, dload, ramaddr, ramstore;

   always #5 CLK = ~CLK;

   mem_arbiter #(
      .BURST_MAX  (BM),
      .STARVE_MAX (SM),
      .CNT_W      (4)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .iwait    (iwait),
      .iload    (iload),
      .dREN     (dREN),
      .dWEN     (dWEN),
      .daddr    (daddr),
      .dstore   (dstore),
      .dwait    (dwait),
      .dload    (dload),
      .ramREN   (ramREN),
      .ramWEN   (ramWEN),
      .ramaddr  (ramaddr),
      .ramstore (ramstore),
      .ramload  (ramload),
      .ramstate (ramstate)
   );

   int vecs = 0;
   int errs = 0;

   // model: owner 0 = nobody, 1 = dcache, 2 = icache
   int own = 0;
   int beats = 0;
   int starve = 0;
   bit done;
   bit i_done_prev = 0;
   bit d_done_prev = 0;
   int d_left = 0;

   bit        rand_ram = 0;
   ramstate_t rs_force = FREE;

   logic        e_ren, e_wen, e_iwait, e_dwait;
   logic [31:0] e_addr, e_store, e_iload, e_dload;

   task automatic chk1(string n, logic a, logic e);
      vecs++;
      if (a !== e) begin
         errs++;
         $display("FAIL %s: got %b want %b at %0t", n, a, e, $time);
      end
   endtask

   task automatic chk32(string n, logic [31:0] a, logic [31:0] e);
      vecs++;
      if (a !== e) begin
         errs++;
         $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
      end
   endtask

   task automatic eval_cmp();
      int r;
      e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0;
      e_iwait = 1; e_dwait = 1; e_iload = 0; e_dload = 0;
      if (own == 1) begin
         e_wen   = dWEN;
         e_ren   = dREN && !dWEN;
         e_addr  = daddr;
         e_store = dstore;
      end else if (own == 2) begin
         e_ren  = 1;
         e_addr = iaddr;
      end
      if (rand_ram) begin
         r = int'($urandom % 10);
         if (e_ren || e_wen)
            ramstate = (r < 5) ? ACCESS : (r < 8) ? BUSY : ERROR;
         else
            ramstate = (r < 5) ? FREE : BUSY;
         ramload = $urandom;
      end else begin
         ramstate = rs_force;
      end
      done = (own != 0) && (ramstate == ACCESS);
      if (own == 1) begin
         e_dwait = !done;
         e_dload = done ? ramload : 32'd0;
      end else if (own == 2) begin
         e_iwait = !done;
         e_iload = done ? ramload : 32'd0;
      end
      #1;
      chk1 ("ramREN",   ramREN,   e_ren);
      chk1 ("ramWEN",   ramWEN,   e_wen);
      chk32("ramaddr",  ramaddr,  e_addr);
      chk32("ramstore", ramstore, e_store);
      chk1 ("iwait",    iwait,    e_iwait);
      chk1 ("dwait",    dwait,    e_dwait);
      chk32("iload",    iload,    e_iload);
      chk32("dload",    dload,    e_dload);
   endtask

   task automatic advance();
      int  nown, nbeats, nstarve;
      bit  dreq;
      dreq   = dREN || dWEN;
      nown   = own;
      nbeats = beats;
      case (own)
         0: begin
            if (starve == SM && iREN) nown = 2;
            else if (dreq)            nown = 1;
            else if (iREN)            nown = 2;
         end
         1: begin
            nbeats = beats + (done ? 1 : 0);
            if (!dreq || (done && nbeats == BM) ||
                (done && starve == SM)) begin
               nown   = 0;
               nbeats = 0;
            end
         end
         default: begin
            if (done || !iREN) nown = 0;
         end
      endcase
      if (!iREN)                     nstarve = 0;
      else if (own != 2 && nown == 2) nstarve = 0;
      else if (own != 2)             nstarve = (starve < SM) ? starve + 1 : SM;
      else                           nstarve = starve;
      i_done_prev = (own == 2) && done;
      d_done_prev = (own == 1) && done;
      @(posedge CLK);
      if (RST) begin
         own = 0; beats = 0; starve = 0;
         i_done_prev = 0; d_done_prev = 0;
      end else begin
         own = nown; beats = nbeats; starve = nstarve;
      end
      @(negedge CLK);
   endtask

   task automatic step();
      eval_cmp();
      advance();
   endtask

   task automatic drive_req(bit busy);
      int op;
      if (iREN && i_done_prev) begin
         iREN  = ($urandom % 3) != 0;
         iaddr = $urandom & 32'hFFFF_FFFC;
      end else if (!iREN) begin
         if ($urandom % 3 == 0) begin
            iREN  = 1;
            iaddr = $urandom & 32'hFFFF_FFFC;
         end
      end else if ($urandom % 40 == 0) begin
         iREN = 0;
      end
      if ((dREN || dWEN) && d_done_prev) begin
         d_left--;
         if (d_left <= 0) begin
            dREN = 0; dWEN = 0;
         end else begin
            daddr  = daddr + 32'd4;
            dstore = $urandom;
         end
      end else if ((dREN || dWEN) && !busy && ($urandom % 50 == 0)) begin
         dREN = 0; dWEN = 0; d_left = 0;
      end
      if (!(dREN || dWEN) && (busy || ($urandom % 4 == 0))) begin
         d_left = 1 + int'($urandom % 6);
         op     = int'($urandom % 4);
         dREN   = (op != 1);
         dWEN   = (op == 1) || (op == 2);
         daddr  = $urandom & 32'hFFFF_FFFC;
         dstore = $urandom;
      end
   endtask

   initial begin
      int n;
      RST = 1; iREN = 0; dREN = 0; dWEN = 0;
      iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
      ramstate = FREE;
      @(negedge CLK);
      @(negedge CLK);
      eval_cmp();
      chk1 ("rst_ramREN",  ramREN,  1'b0);
      chk1 ("rst_ramWEN",  ramWEN,  1'b0);
      chk1 ("rst_iwait",   iwait,   1'b1);
      chk1 ("rst_dwait",   dwait,   1'b1);
      chk32("rst_ramaddr", ramaddr, 32'd0);
      advance();
      RST = 0;

      // single icache word, RAM answers two cycles after ramREN
      iREN = 1; iaddr = 32'h40; rs_force = FREE;
      eval_cmp(); chk1("t2_ren_c0", ramREN, 1'b0); advance();
      rs_force = BUSY;
      eval_cmp(); chk1("t2_ren_c1", ramREN, 1'b1);
      chk32("t2_addr", ramaddr, 32'h40); advance();
      step();
      rs_force = ACCESS; ramload = 32'hDEADBEEF;
      eval_cmp(); chk1("t2_iwait", iwait, 1'b0);
      chk32("t2_iload", iload, 32'hDEADBEEF); advance();
      iREN = 0; rs_force = FREE;
      eval_cmp(); chk1("t2_idle", ramREN, 1'b0); advance();

      // four-word write burst holds the grant against icache
      iREN = 1; iaddr = 32'h80; dWEN = 1; daddr = 32'h100;
      dstore = $urandom; rs_force = ACCESS;
      step();
      for (int k = 0; k < 4; k++) begin
         daddr  = 32'h100 + 32'(4 * k);
         dstore = $urandom;
         eval_cmp();
         chk1 ("t3_wen",  ramWEN,  1'b1);
         chk1 ("t3_ren",  ramREN,  1'b0);
         chk32("t3_addr", ramaddr, 32'h100 + 32'(4 * k));
         advance();
      end
      dWEN = 0;
      eval_cmp(); chk1("t3_gap", ramREN, 1'b0); advance();
      eval_cmp(); chk32("t3_iaddr", ramaddr, 32'h80);
      chk1("t3_iren", ramREN, 1'b1); advance();
      iREN = 0;
      step();

      // read and write together: the write wins
      dREN = 1; dWEN = 1; daddr = 32'h200; dstore = 32'hA5A5_1234;
      rs_force = BUSY;
      step();
      eval_cmp();
      chk1 ("t4_wen",   ramWEN,   1'b1);
      chk1 ("t4_ren",   ramREN,   1'b0);
      chk32("t4_store", ramstore, 32'hA5A5_1234);
      advance();
      rs_force = ACCESS; step();
      dREN = 0; dWEN = 0; rs_force = FREE; step();

      // ERROR retries keep the address and count no beat
      dREN = 1; daddr = 32'h300; rs_force = FREE;
      step();
      rs_force = ERROR;
      for (int k = 0; k < 3; k++) begin
         eval_cmp();
         chk1 ("t6_dwait", dwait,   1'b1);
         chk32("t6_addr",  ramaddr, 32'h300);
         advance();
      end
      rs_force = ACCESS;
      eval_cmp(); chk1("t6_done", dwait, 1'b0); advance();
      for (int k = 1; k < 4; k++) begin
         daddr = 32'h300 + 32'(4 * k);
         eval_cmp(); chk1("t6_burst", ramREN, 1'b1); advance();
      end
      eval_cmp(); chk1("t6_quota", ramREN, 1'b0); advance();
      dREN = 0; rs_force = FREE; step();

      // continuous dcache traffic: icache granted after starvation
      iREN = 1; iaddr = 32'hC0; dWEN = 1; daddr = 32'h400;
      rs_force = ACCESS;
      n = 0;
      while (n < 30) begin
         eval_cmp();
         if (ramREN && !ramWEN && ramaddr == 32'hC0) break;
         advance();
         daddr = daddr + 32'd4;
         n++;
      end
      chk32("t5_cycles", 32'(n), 32'd10);
      advance();
      iREN = 0; dWEN = 0; rs_force = FREE;
      step();

      // reset in the middle of a dcache write
      dWEN = 1; daddr = 32'h500; dstore = 32'h1111_2222;
      rs_force = BUSY;
      step();
      eval_cmp(); chk1("t1_wen_pre", ramWEN, 1'b1);
      #2 RST = 1;
      #1;
      chk1("t1_wen_rst",   ramWEN, 1'b0);
      chk1("t1_dwait_rst", dwait,  1'b1);
      advance();
      RST = 0;
      eval_cmp(); chk1("t1_idle", ramWEN, 1'b0); advance();
      dWEN = 0; step();
      step();

      // randomized traffic, then a phase with dcache never idle
      rand_ram = 1;
      for (int c = 0; c < 3000; c++) begin
         drive_req(1'b0);
         step();
      end
      for (int c = 0; c < 1500; c++) begin
         drive_req(1'b1);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
